led_driver_shift_reg_mc: RTL and testbench

Multi-channel, double-buffered successor to the single-channel LED bit serialiser. It accepts one parallel word per channel through a valid/ready handshake and holds the next word while the current one shifts out. It presents one bit per channel per `next_bit` strobe, with a runtime-selectable word length and a build-time bit order. It sits between the frame/pixel fetch logic and the per-strip LED waveform generators, which issue `next_bit` and consume `bit_val`.

---
 rtl/led_driver_shift_reg_mc_if.sv | 28 ++
 rtl/led_driver_shift_reg_mc.sv | 154 +++++++++++++++
 tb/tb_led_driver_shift_reg_mc.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_driver_shift_reg_mc_if.sv
// Parallel-word load and per-bit strobe bundle shared by the LED serialiser and
// the fetch/waveform logic around it.
interface led_driver_shift_reg_mc_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 24,
  parameter int LEN_W      = $clog2(DATA_WIDTH) + 1
);
  logic [CHANNELS*DATA_WIDTH-1:0] s_data;
  logic [LEN_W-1:0]               s_len;
  logic                           s_valid;
  logic                           s_ready;
  logic                           next_bit;
  logic [CHANNELS-1:0]            bit_val;
  logic                           bit_valid;
  logic                           last_bit;
  logic                           word_done;
  logic                           underrun;

  modport master (
    output s_data, s_len, s_valid, next_bit,
    input  s_ready, bit_val, bit_valid, last_bit, word_done, underrun
  );

  modport slave (
    input  s_data, s_len, s_valid, next_bit,
    output s_ready, bit_val, bit_valid, last_bit, word_done, underrun
  );
endinterface

// File: rtl/led_driver_shift_reg_mc.sv
// Double-buffered multi-channel LED bit serialiser: a holding word waits while the
// active word is presented one bit per channel per next_bit strobe.
module led_driver_shift_reg_mc #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 24,
  parameter int MSB_FIRST  = 1,
  parameter int LEN_W      = $clog2(DATA_WIDTH) + 1
) (
  input logic                     clk,
  input logic                     reset,
  led_driver_shift_reg_mc_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [CHANNELS*DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [LEN_W-1:0]               hold_len_q, hold_len_d;
  logic                           hold_full_q, hold_full_d;
  logic [CHANNELS*DATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [LEN_W-1:0]               act_len_q, act_len_d;
  logic [LEN_W-1:0]               pos_q, pos_d;
  logic                           word_done_q, word_done_d;
  logic                           underrun_q, underrun_d;

  logic                           active_s;
  logic                           last_s;
  logic                           accept_s;
  logic                           promote_s;
  logic [LEN_W-1:0]               len_clamp_s;
  logic [LEN_W-1:0]               idx_s;
  logic [CHANNELS-1:0]            bit_val_s;

  function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] word,
                                    input logic [LEN_W-1:0] idx);
    logic [DATA_WIDTH-1:0] shifted;
    shifted = word >> idx;
    return shifted[0];
  endfunction

  assign active_s  = (state_q == SHIFT);
  assign last_s    = active_s && (pos_q == (act_len_q - LEN_W'(1)));
  assign accept_s  = bus.s_valid && !hold_full_q;
  // Promotion is gap-free: the held word takes over on the same edge the last bit is consumed.
  assign promote_s = hold_full_q && (!active_s || (bus.next_bit && last_s));

  // Zero or oversize lengths fall back to a full-width word.
  always_comb begin
    if ((bus.s_len == {LEN_W{1'b0}}) || (bus.s_len > LEN_W'(DATA_WIDTH))) begin
      len_clamp_s = LEN_W'(DATA_WIDTH);
    end else begin
      len_clamp_s = bus.s_len;
    end
  end

  // Next-state logic for both buffer stages, bit position and event pulses.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_full_d = hold_full_q;
    act_data_d  = act_data_q;
    act_len_d   = act_len_q;
    pos_d       = pos_q;
    word_done_d = bus.next_bit && last_s;
    underrun_d  = bus.next_bit && !active_s;

    if (accept_s) begin
      hold_data_d = bus.s_data;
      hold_len_d  = len_clamp_s;
      hold_full_d = 1'b1;
    end else if (promote_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end

    case (state_q)
      IDLE: begin
        if (promote_s) begin
          act_data_d = hold_data_q;
          act_len_d  = hold_len_q;
          pos_d      = {LEN_W{1'b0}};
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (promote_s) begin
          act_data_d = hold_data_q;
          act_len_d  = hold_len_q;
          pos_d      = {LEN_W{1'b0}};
          state_d    = SHIFT;
        end else if (bus.next_bit && last_s) begin
          state_d = IDLE;
        end else if (bus.next_bit) begin
          pos_d = pos_q + LEN_W'(1);
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards both stages at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_data_q <= {(CHANNELS*DATA_WIDTH){1'b0}};
      hold_len_q  <= {LEN_W{1'b0}};
      hold_full_q <= 1'b0;
      act_data_q  <= {(CHANNELS*DATA_WIDTH){1'b0}};
      act_len_q   <= {LEN_W{1'b0}};
      pos_q       <= {LEN_W{1'b0}};
      word_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_full_q <= hold_full_d;
      act_data_q  <= act_data_d;
      act_len_q   <= act_len_d;
      pos_q       <= pos_d;
      word_done_q <= word_done_d;
      underrun_q  <= underrun_d;
    end
  end

  // Current bit of every channel, decoded from the active word and position.
  always_comb begin
    bit_val_s = {CHANNELS{1'b0}};
    if (MSB_FIRST != 0) begin
      idx_s = act_len_q - LEN_W'(1) - pos_q;
    end else begin
      idx_s = pos_q;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      bit_val_s[c] = active_s ? pick_bit(act_data_q[c*DATA_WIDTH +: DATA_WIDTH], idx_s) : 1'b0;
    end
  end

  assign bus.s_ready   = !hold_full_q;
  assign bus.bit_val   = bit_val_s;
  assign bus.bit_valid = active_s;
  assign bus.last_bit  = last_s;
  assign bus.word_done = word_done_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_led_driver_shift_reg_mc.sv
// Drives an MSB-first and an LSB-first instance in lockstep and checks both
// against a queue-based model of the word/bit stream.
module tb_led_driver_shift_reg_mc;

  localparam int CH = 2;
  localparam int DW = 8;
  localparam int LW = 4;

  logic           clk;
  logic           reset;
  logic           s_valid;
  logic [CH*DW-1:0] s_data;
  logic [LW-1:0]  s_len;
  logic           next_bit;

  int n_cmp;
  int n_fail;
  int cyc;

  led_driver_shift_reg_mc_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .LEN_W(LW)) if_m ();
  led_driver_shift_reg_mc_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .LEN_W(LW)) if_l ();

  assign if_m.s_data   = s_data;
  assign if_m.s_len    = s_len;
  assign if_m.s_valid  = s_valid;
  assign if_m.next_bit = next_bit;
  assign if_l.s_data   = s_data;
  assign if_l.s_len    = s_len;
  assign if_l.s_valid  = s_valid;
  assign if_l.next_bit = next_bit;

  led_driver_shift_reg_mc #(.CHANNELS(CH), .DATA_WIDTH(DW), .MSB_FIRST(1), .LEN_W(LW)) dut_m (
    .clk(clk), .reset(reset), .bus(if_m.slave)
  );
  led_driver_shift_reg_mc #(.CHANNELS(CH), .DATA_WIDTH(DW), .MSB_FIRST(0), .LEN_W(LW)) dut_l (
    .clk(clk), .reset(reset), .bus(if_l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one optional held word plus the remaining bits of the active word.
  logic            hold_v;
  logic [CH*DW-1:0] hold_d;
  int              hold_l;
  logic [CH-1:0]   cur_m[$];
  logic [CH-1:0]   cur_l[$];
  logic            exp_wd;
  logic            exp_ur;

  logic [7:0] cap_m0, cap_m1, cap_l0, cap_l1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    hold_v = 1'b0;
    hold_d = '0;
    hold_l = 0;
    cur_m.delete();
    cur_l.delete();
    exp_wd = 1'b0;
    exp_ur = 1'b0;
  endtask

  task automatic model_load(input logic [CH*DW-1:0] d, input int l);
    for (int i = 0; i < l; i++) begin
      cur_m.push_back({d[DW + (l-1-i)], d[l-1-i]});
      cur_l.push_back({d[DW + i], d[i]});
    end
  endtask

  task automatic model_step(input logic v, input logic [CH*DW-1:0] d,
                            input logic [LW-1:0] l, input logic nb);
    logic hold_was;
    hold_was = hold_v;
    exp_wd = 1'b0;
    exp_ur = 1'b0;
    if (nb) begin
      if (cur_m.size() > 0) begin
        cur_m.delete(0);
        cur_l.delete(0);
        if (cur_m.size() == 0) exp_wd = 1'b1;
      end else begin
        exp_ur = 1'b1;
      end
    end
    if (hold_was && cur_m.size() == 0) begin
      model_load(hold_d, hold_l);
      hold_v = 1'b0;
    end else if (!hold_was && v) begin
      hold_v = 1'b1;
      hold_d = d;
      hold_l = (l == 0 || int'(l) > DW) ? DW : int'(l);
    end
  endtask

  task automatic check_outputs();
    logic [6:0] em, el;
    logic [CH-1:0] bm, bl;
    bm = (cur_m.size() > 0) ? cur_m[0] : '0;
    bl = (cur_l.size() > 0) ? cur_l[0] : '0;
    em = {!hold_v, cur_m.size() > 0, cur_m.size() == 1, exp_wd, exp_ur, bm};
    el = {!hold_v, cur_l.size() > 0, cur_l.size() == 1, exp_wd, exp_ur, bl};
    chk("msb_outs", {25'd0, if_m.s_ready, if_m.bit_valid, if_m.last_bit,
                     if_m.word_done, if_m.underrun, if_m.bit_val}, {25'd0, em});
    chk("lsb_outs", {25'd0, if_l.s_ready, if_l.bit_valid, if_l.last_bit,
                     if_l.word_done, if_l.underrun, if_l.bit_val}, {25'd0, el});
  endtask

  task automatic cycle(input logic v, input logic [CH*DW-1:0] d,
                       input logic [LW-1:0] l, input logic nb);
    s_valid = v; s_data = d; s_len = l; next_bit = nb;
    if (nb) begin
      cap_m0 = {cap_m0[6:0], if_m.bit_val[0]};
      cap_m1 = {cap_m1[6:0], if_m.bit_val[1]};
      cap_l0 = {if_l.bit_val[0], cap_l0[7:1]};
      cap_l1 = {if_l.bit_val[1], cap_l1[7:1]};
    end
    @(posedge clk);
    cyc++;
    model_step(v, d, l, nb);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic clear_caps();
    cap_m0 = '0; cap_m1 = '0; cap_l0 = '0; cap_l1 = '0;
  endtask

  initial begin
    int n;
    n_cmp = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_len = '0; next_bit = 1'b0;
    clear_caps();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("reset_ready", {31'd0, if_m.s_ready}, 32'd1);
    reset = 1'b0;

    // MSB-first basic word on both instances
    clear_caps();
    cycle(1'b1, 16'h3CA5, 4'd8, 1'b0);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);
    repeat (8) cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    chk("basic_wd", {31'd0, if_m.word_done}, 32'd1);
    chk("basic_m0", {24'd0, cap_m0}, 32'hA5);
    chk("basic_m1", {24'd0, cap_m1}, 32'h3C);
    chk("basic_l0", {24'd0, cap_l0}, 32'hA5);
    chk("basic_l1", {24'd0, cap_l1}, 32'h3C);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);

    // Short length, both bit orders
    clear_caps();
    cycle(1'b1, 16'h0006, 4'd3, 1'b0);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);
    repeat (3) cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    chk("short_m0", {29'd0, cap_m0[2:0]}, 32'd6);
    chk("short_l0", {29'd0, cap_l0[7:5]}, 32'd6);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);

    // Back-to-back words with no bubble
    cycle(1'b1, 16'h0000, 4'd8, 1'b0);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);
    cycle(1'b1, 16'h00FF, 4'd8, 1'b1);
    chk("b2b_ready_low", {31'd0, if_m.s_ready}, 32'd0);
    repeat (6) cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    chk("b2b_valid", {31'd0, if_m.bit_valid}, 32'd1);
    chk("b2b_bit", {31'd0, if_m.bit_val[0]}, 32'd1);
    chk("b2b_ready_high", {31'd0, if_m.s_ready}, 32'd1);
    repeat (8) cycle(1'b0, 16'h0000, 4'd0, 1'b1);

    // Underrun with nothing loaded
    cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    chk("underrun_pulse", {31'd0, if_m.underrun}, 32'd1);
    chk("underrun_valid", {31'd0, if_m.bit_valid}, 32'd0);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);
    chk("underrun_clear", {31'd0, if_m.underrun}, 32'd0);

    // Length clamp: 0 and 12 both shift a full 8 bits
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 16'h5A5A, (k == 0) ? 4'd0 : 4'd12, 1'b0);
      cycle(1'b0, 16'h0000, 4'd0, 1'b0);
      n = 0;
      for (int t = 0; t < 20; t++) begin
        cycle(1'b0, 16'h0000, 4'd0, 1'b1);
        n++;
        if (if_m.word_done) break;
      end
      chk("clamp_len", n, 32'd8);
    end

    // Mid-word reset with a word held behind the active one
    cycle(1'b1, 16'h1234, 4'd8, 1'b0);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);
    cycle(1'b1, 16'hABCD, 4'd5, 1'b1);
    repeat (2) cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_valid", {31'd0, if_m.bit_valid}, 32'd0);
    chk("rst_ready", {31'd0, if_m.s_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    clear_caps();
    cycle(1'b1, 16'h00C3, 4'd8, 1'b0);
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);
    repeat (8) cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    chk("post_rst_m0", {24'd0, cap_m0}, 32'hC3);
    chk("post_rst_l0", {24'd0, cap_l0}, 32'hC3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
